// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: ROM read port, decode valid/ready handshake and branch redirect.
interface fetch_unit_if #(
   parameter int unsigned AWIDTH = 12,
   parameter int unsigned DWIDTH = 32
);
   logic [AWIDTH-1:0] rom_addr;
   logic [DWIDTH-1:0] rom_qout;
   logic              if_valid;
   logic              if_ready;
   logic [DWIDTH-1:0] if_inst;
   logic [31:0]       if_pc;
   logic              br_taken;
   logic [31:0]       br_target;

   // Fetch unit side
   modport master (
      output rom_addr, if_valid, if_inst, if_pc,
      input  rom_qout, if_ready, br_taken, br_target
   );

   // ROM / decode / execute side
   modport slave (
      input  rom_addr, if_valid, if_inst, if_pc,
      output rom_qout, if_ready, br_taken, br_target
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC, one in-flight synchronous ROM read,
// 2-entry output FIFO towards decode, branch redirect with flush.
// Optional feature macro: FETCH_CNT_EN adds the fetch_cnt accepted-instruction counter.
module fetch_unit #(
   parameter int unsigned AWIDTH   = 12,
   parameter int unsigned DWIDTH   = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         rst_n,
   fetch_unit_if.master bus
`ifdef FETCH_CNT_EN
   ,
   output logic [31:0]  fetch_cnt
`endif
);

   localparam logic [31:0] PC_INIT = RESET_PC & ~32'h3;
   localparam logic [31:0] PC_STEP = 32'd4;

   typedef struct packed {
      logic [DWIDTH-1:0] inst;
      logic [31:0]       pc;
   } entry_t;

   logic [31:0] req_pc_q, req_pc_n;
   logic        infl_q, infl_n;
   logic [31:0] infl_pc_q, infl_pc_n;
   logic        v0_q, v0_n;
   logic        v1_q, v1_n;
   entry_t      head_q, head_n;
   entry_t      tail_q, tail_n;

   logic        pop;
   logic        push;
   logic        issue;
   logic [1:0]  occ;
   entry_t      resp;

   // Next-state: issue decision, in-flight tracking, FIFO push/pop, redirect flush
   always_comb begin
      req_pc_n  = req_pc_q;
      infl_n    = infl_q;
      infl_pc_n = infl_pc_q;
      v0_n      = v0_q;
      v1_n      = v1_q;
      head_n    = head_q;
      tail_n    = tail_q;

      pop   = v0_q & bus.if_ready;
      push  = infl_q & ~bus.br_taken;
      occ   = 2'(v0_q) + 2'(v1_q) + 2'(infl_q);
      issue = ~bus.br_taken & ((occ - 2'(pop)) <= 2'd1);
      resp  = '{inst: bus.rom_qout, pc: infl_pc_q};

      if (bus.br_taken) begin
         // Flush buffered and in-flight fetches; restart at the aligned target
         v0_n     = 1'b0;
         v1_n     = 1'b0;
         infl_n   = 1'b0;
         req_pc_n = bus.br_target & ~32'h3;
      end else begin
         infl_n = issue;
         if (issue) begin
            infl_pc_n = req_pc_q;
            req_pc_n  = req_pc_q + PC_STEP;
         end
         if (pop) begin
            if (v1_q) begin
               head_n = tail_q;
               if (push) begin
                  tail_n = resp;
               end else begin
                  v1_n = 1'b0;
               end
            end else if (push) begin
               head_n = resp;
            end else begin
               v0_n = 1'b0;
            end
         end else if (push) begin
            if (!v0_q) begin
               head_n = resp;
               v0_n   = 1'b1;
            end else begin
               tail_n = resp;
               v1_n   = 1'b1;
            end
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_pc_q  <= PC_INIT;
         infl_q    <= 1'b0;
         infl_pc_q <= '0;
         v0_q      <= 1'b0;
         v1_q      <= 1'b0;
         head_q    <= '0;
         tail_q    <= '0;
      end else begin
         req_pc_q  <= req_pc_n;
         infl_q    <= infl_n;
         infl_pc_q <= infl_pc_n;
         v0_q      <= v0_n;
         v1_q      <= v1_n;
         head_q    <= head_n;
         tail_q    <= tail_n;
      end
   end

   // The issue rule must never let a push land on a full FIFO
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop && v1_q));

`ifdef FETCH_CNT_EN
   // Count instructions accepted by decode; survives redirects
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt <= '0;
      end else if (pop) begin
         fetch_cnt <= fetch_cnt + 32'd1;
      end
   end
`endif

   assign bus.rom_addr = req_pc_q[AWIDTH+1:2];
   assign bus.if_valid = v0_q;
   assign bus.if_inst  = head_q.inst;
   assign bus.if_pc    = head_q.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit against a stream-level model:
// expected delivery PC, restart latency, and PC-derived ROM contents.
module tb_fetch_unit;

   localparam int unsigned AW      = 12;
   localparam int unsigned DW      = 32;
   localparam logic [31:0] RST_PC  = 32'h0000_0000;
   localparam logic [31:0] RST_PC2 = 32'h0000_3FFC;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fetch_unit_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();
   fetch_unit_if #(.AWIDTH(AW), .DWIDTH(DW)) bus2 ();

`ifdef FETCH_CNT_EN
   logic [31:0] cnt;
   logic [31:0] cnt2;
`endif

   fetch_unit #(.AWIDTH(AW), .DWIDTH(DW), .RESET_PC(RST_PC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef FETCH_CNT_EN
      ,
      .fetch_cnt (cnt)
`endif
   );

   fetch_unit #(.AWIDTH(AW), .DWIDTH(DW), .RESET_PC(RST_PC2)) dut_wrap (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
`ifdef FETCH_CNT_EN
      ,
      .fetch_cnt (cnt2)
`endif
   );

   function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
      return 32'h1000_0000 + 32'(a);
   endfunction

   // Synchronous-read ROMs: word i holds 0x1000_0000 + i
   always @(posedge clk) begin
      bus.rom_qout  <= rom_word(bus.rom_addr);
      bus2.rom_qout <= rom_word(bus2.rom_addr);
   end

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_pc;
   logic [31:0] last_tgt;
   logic [31:0] n_pop;
   int          since;
   int          w_cyc;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // One cycle: sample at negedge, check against model, drive next inputs, advance model
   task automatic step(input logic rdy, input logic br, input logic [31:0] tgt);
      logic            exp_valid;
      logic            pop;
      logic [AW-1:0]   wa;
      @(negedge clk);
      exp_valid = (since >= 3);
      chk("valid", 32'(bus.if_valid), 32'(exp_valid));
      if (exp_valid) begin
         chk("pc", bus.if_pc, exp_pc);
         chk("inst", bus.if_inst, rom_word(exp_pc[AW+1:2]));
         wa = exp_pc[AW+1:2] + AW'(2);
         chk("rom_addr_run", 32'(bus.rom_addr), 32'(wa));
      end
      if (since == 1) begin
         chk("rom_addr_tgt", 32'(bus.rom_addr), 32'(last_tgt[AW+1:2]));
      end
`ifdef FETCH_CNT_EN
      chk("fetch_cnt", cnt, n_pop);
`endif
      if (w_cyc == 1) begin
         chk("wrap_addr1", 32'(bus2.rom_addr), 32'h0);
         chk("wrap_valid1", 32'(bus2.if_valid), 32'h0);
      end else if (w_cyc == 2) begin
         chk("wrap_valid2", 32'(bus2.if_valid), 32'h1);
         chk("wrap_pc2", bus2.if_pc, 32'h0000_3FFC);
         chk("wrap_inst2", bus2.if_inst, 32'h1000_0FFF);
      end else if (w_cyc == 3) begin
         chk("wrap_pc3", bus2.if_pc, 32'h0000_4000);
         chk("wrap_inst3", bus2.if_inst, 32'h1000_0000);
`ifdef FETCH_CNT_EN
         chk("wrap_cnt3", cnt2, 32'd1);
`endif
      end
      if (w_cyc >= 3) w_cyc = -1;
      else if (w_cyc >= 0) w_cyc++;

      bus.if_ready  = rdy;
      bus.br_taken  = br;
      bus.br_target = tgt;

      pop = exp_valid & rdy;
      if (pop) n_pop = n_pop + 32'd1;
      if (br) begin
         exp_pc   = tgt & ~32'h3;
         last_tgt = tgt;
         since    = 1;
      end else begin
         if (pop) exp_pc = exp_pc + 32'd4;
         if (since < 3) since++;
      end
   endtask

   // Release reset at a negedge; the following posedge is fetch cycle 0
   task automatic release_reset();
      @(negedge clk);
      rst_n         = 1'b1;
      bus.if_ready  = 1'b1;
      bus.br_taken  = 1'b0;
      bus.br_target = '0;
      exp_pc        = RST_PC & ~32'h3;
      last_tgt      = RST_PC;
      n_pop         = '0;
      since         = 2;
   endtask

   task automatic rand_steps(input int n);
      for (int i = 0; i < n; i++) begin
         step(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), $urandom);
      end
   endtask

   initial begin
      bus.if_ready   = 1'b0;
      bus.br_taken   = 1'b0;
      bus.br_target  = '0;
      bus2.if_ready  = 1'b1;
      bus2.br_taken  = 1'b0;
      bus2.br_target = '0;
      w_cyc          = -1;
      since          = 0;
      n_pop          = '0;
      exp_pc         = '0;
      last_tgt       = '0;

      #12;
      chk("rst_valid", 32'(bus.if_valid), 32'h0);
      chk("rst_pc", bus.if_pc, 32'h0);
      chk("rst_inst", bus.if_inst, 32'h0);
      chk("rst_addr", 32'(bus.rom_addr), 32'h0);
      chk("rst_addr_wrap", 32'(bus2.rom_addr), 32'h0000_0FFF);
`ifdef FETCH_CNT_EN
      chk("rst_cnt", cnt, 32'h0);
`endif

      release_reset();
      w_cyc = 1;

      // Stream, then stall three cycles with head at 0x8
      repeat (3) step(1'b1, 1'b0, '0);
      repeat (3) step(1'b0, 1'b0, '0);
      repeat (6) step(1'b1, 1'b0, '0);

      // Redirect to 0x100, then unaligned 0x103, then back-to-back 0x200/0x300
      step(1'b1, 1'b1, 32'h0000_0100);
      repeat (6) step(1'b1, 1'b0, '0);
      step(1'b1, 1'b1, 32'h0000_0103);
      repeat (5) step(1'b1, 1'b0, '0);
      step(1'b1, 1'b1, 32'h0000_0200);
      step(1'b1, 1'b1, 32'h0000_0300);
      repeat (6) step(1'b1, 1'b0, '0);

      // Redirect near the top of the 32-bit space to exercise PC wrap
      step(1'b1, 1'b1, 32'hFFFF_FFF8);
      repeat (8) step(1'b1, 1'b0, '0);

      rand_steps(600);

      // Asynchronous reset between clock edges
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_valid", 32'(bus.if_valid), 32'h0);
      chk("async_pc", bus.if_pc, 32'h0);
      chk("async_inst", bus.if_inst, 32'h0);
`ifdef FETCH_CNT_EN
      chk("async_cnt", cnt, 32'h0);
`endif
      bus.br_taken = 1'b0;
      repeat (2) @(negedge clk);
      release_reset();

      repeat (12) step(1'b1, 1'b0, '0);
      rand_steps(300);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
